// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: state encoding, reset/halt
// addresses and the instruction step size.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

  // Sequential PC advance; wraps naturally at 32 bits.
  function automatic logic [31:0] pc_advance(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register between fetch and the control path.
// Priority: reset > flush > load > consume > hold.
module fetch_out_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic        i_ready,
  input  logic [31:0] i_word,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_word,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_word;
  logic [31:0] r_pc;

  // Capture, flush or retire the held instruction word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_word  <= 32'd0;
      r_pc    <= 32'd0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_word  <= i_word;
      r_pc    <= i_pc;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_word;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory read/waitrequest
// bus and hands words to the control path over valid/ready. Halts at
// HALT_ADDR. Build option FETCH_ALIGN_CHECK_EN turns misaligned redirects
// into a sticky fetch_fault and a halt; without it the low address bits
// of a redirect are ignored.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_read_addr,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_readdata,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        active,
  output logic        fetch_fault
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_target;
  logic         r_fault;
  logic         r_active;

  logic [31:0]  w_redir_addr;
  logic         w_misaligned;
  logic         w_slot_free;
  logic         w_read;
  logic         w_accept;
  logic         w_stall;
  logic         w_at_halt;
  logic         w_fault_any;
  logic         w_flush;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_redir_addr = redirect_addr;
  assign w_misaligned = (redirect_addr[1:0] != 2'b00);
`else
  logic w_unused_low;
  assign w_redir_addr = {redirect_addr[31:2], 2'b00};
  assign w_misaligned = 1'b0;
  assign w_unused_low = ^redirect_addr[1:0];
`endif

  assign w_slot_free = !instr_valid || instr_ready;
  assign w_at_halt   = (r_pc == HALT_ADDR);
  assign w_accept    = w_read && !instr_waitrequest;
  assign w_stall     = w_read && instr_waitrequest;
  assign w_fault_any = r_fault || (redirect_valid && w_misaligned);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: redirects, drain completion and halt detection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (redirect_valid) begin
          if (w_stall) begin
            w_state_nxt = DRAIN;
          end else if (w_misaligned) begin
            w_state_nxt = HALTED;
          end else begin
            w_state_nxt = RUN;
          end
        end else if (w_at_halt && w_slot_free) begin
          w_state_nxt = HALTED;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (!instr_waitrequest) begin
          w_state_nxt = w_fault_any ? HALTED : RUN;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  // Output decode: memory request and output-register flush.
  always_comb begin
    w_read  = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      RUN: begin
        w_read  = reset && w_slot_free && !w_at_halt;
        w_flush = redirect_valid;
      end
      DRAIN: begin
        w_read  = reset;
        w_flush = 1'b1;
      end
      HALTED: begin
        w_read  = 1'b0;
        w_flush = 1'b0;
      end
      default: begin
        w_read  = 1'b0;
        w_flush = 1'b0;
      end
    endcase
  end

  // PC, pending redirect target, sticky fault and running flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc     <= RESET_VECTOR;
      r_target <= 32'd0;
      r_fault  <= 1'b0;
      r_active <= 1'b1;
    end else begin
      r_active <= (w_state_nxt != HALTED);
      case (r_state)
        RUN: begin
          if (redirect_valid) begin
            if (w_misaligned) begin
              r_fault <= 1'b1;
            end else begin
              r_fault <= r_fault;
            end
            if (w_stall) begin
              r_target <= w_redir_addr;
            end else begin
              r_pc <= w_redir_addr;
            end
          end else if (w_accept) begin
            r_pc <= pc_advance(r_pc);
          end else begin
            r_pc <= r_pc;
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            r_target <= w_redir_addr;
            if (w_misaligned) begin
              r_fault <= 1'b1;
            end else begin
              r_fault <= r_fault;
            end
          end else begin
            r_target <= r_target;
          end
          if (!instr_waitrequest && !w_fault_any) begin
            r_pc <= redirect_valid ? w_redir_addr : r_target;
          end else begin
            r_pc <= r_pc;
          end
        end
        HALTED: begin
          r_pc <= r_pc;
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  fetch_out_reg u_out (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_load  (w_accept),
    .i_ready (instr_ready),
    .i_word  (instr_readdata),
    .i_pc    (r_pc),
    .o_valid (instr_valid),
    .o_word  (instr_word),
    .o_pc    (instr_pc)
  );

  assign instr_read      = w_read;
  assign instr_read_addr = r_pc;
  assign active          = r_active;
  assign fetch_fault     = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Memory returns ~address with a
// bench-controlled waitrequest; expected words are written as constants.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_read_addr;
  logic        instr_read;
  logic        instr_waitrequest;
  logic [31:0] instr_readdata;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        active;
  logic        fetch_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign instr_readdata = ~instr_read_addr;

  instr_fetch dut (
    .clk               (clk),
    .reset             (reset),
    .instr_read_addr   (instr_read_addr),
    .instr_read        (instr_read),
    .instr_waitrequest (instr_waitrequest),
    .instr_readdata    (instr_readdata),
    .instr_word        (instr_word),
    .instr_pc          (instr_pc),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .redirect_valid    (redirect_valid),
    .redirect_addr     (redirect_addr),
    .active            (active),
    .fetch_fault       (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges, release it 1 time unit after an edge.
  task automatic do_reset();
    reset = 1'b0; instr_ready = 1'b1; instr_waitrequest = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0; instr_ready = 1'b1; instr_waitrequest = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    // Reset state
    chk1("rst_read", instr_read, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_word", instr_word, 32'h0000_0000);
    chk("rst_pc", instr_pc, 32'h0000_0000);
    chk1("rst_active", active, 1'b1);
    chk1("rst_fault", fetch_fault, 1'b0);

    // T1: zero-wait streaming
    reset = 1'b1; #1;
    chk1("t1_read0", instr_read, 1'b1);
    chk("t1_addr0", instr_read_addr, 32'hBFC0_0000);
    chk1("t1_valid0", instr_valid, 1'b0);
    @(posedge clk); #2;
    chk1("t1_valid1", instr_valid, 1'b1);
    chk("t1_word1", instr_word, 32'h403F_FFFF);
    chk("t1_pc1", instr_pc, 32'hBFC0_0000);
    chk("t1_addr1", instr_read_addr, 32'hBFC0_0004);
    @(posedge clk); #2;
    chk("t1_word2", instr_word, 32'h403F_FFFB);
    chk("t1_pc2", instr_pc, 32'hBFC0_0004);
    chk("t1_addr2", instr_read_addr, 32'hBFC0_0008);

    // T2: three wait cycles on BFC00004
    do_reset();
    @(posedge clk); #1 instr_waitrequest = 1'b1; #1;
    chk("t2_addr_w1", instr_read_addr, 32'hBFC0_0004);
    chk1("t2_read_w1", instr_read, 1'b1);
    @(posedge clk); #2;
    chk("t2_addr_w2", instr_read_addr, 32'hBFC0_0004);
    chk1("t2_read_w2", instr_read, 1'b1);
    chk1("t2_valid_w2", instr_valid, 1'b0);
    @(posedge clk); #2;
    chk("t2_addr_w3", instr_read_addr, 32'hBFC0_0004);
    chk1("t2_valid_w3", instr_valid, 1'b0);
    @(posedge clk); #1 instr_waitrequest = 1'b0; #1;
    chk("t2_addr_w4", instr_read_addr, 32'hBFC0_0004);
    chk1("t2_read_w4", instr_read, 1'b1);
    @(posedge clk); #2;
    chk1("t2_valid_d", instr_valid, 1'b1);
    chk("t2_word_d", instr_word, 32'h403F_FFFB);
    chk("t2_pc_d", instr_pc, 32'hBFC0_0004);
    chk("t2_addr_n", instr_read_addr, 32'hBFC0_0008);
    @(posedge clk); #2;
    chk("t2_pc_n", instr_pc, 32'hBFC0_0008);
    chk("t2_word_n", instr_word, 32'h403F_FFF7);

    // T3: control path backpressure for two cycles
    instr_ready = 1'b0; #1;
    chk1("t3_read_bp1", instr_read, 1'b0);
    @(posedge clk); #2;
    chk1("t3_valid_bp2", instr_valid, 1'b1);
    chk("t3_word_bp2", instr_word, 32'h403F_FFF7);
    chk("t3_pc_bp2", instr_pc, 32'hBFC0_0008);
    chk1("t3_read_bp2", instr_read, 1'b0);
    instr_ready = 1'b1; #1;
    chk1("t3_read_res", instr_read, 1'b1);
    chk("t3_addr_res", instr_read_addr, 32'hBFC0_000C);
    @(posedge clk); #2;
    chk("t3_word_res", instr_word, 32'h403F_FFF3);
    chk("t3_pc_res", instr_pc, 32'hBFC0_000C);

    // T4: redirect while BFC00008 is stalled
    do_reset();
    @(posedge clk); #2;
    @(posedge clk); #1;
    instr_waitrequest = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h0040_0010; #1;
    chk("t4_addr_st", instr_read_addr, 32'hBFC0_0008);
    @(posedge clk); #1 redirect_valid = 1'b0; #1;
    chk1("t4_read_dr", instr_read, 1'b1);
    chk("t4_addr_dr", instr_read_addr, 32'hBFC0_0008);
    chk1("t4_valid_dr", instr_valid, 1'b0);
    instr_waitrequest = 1'b0;
    @(posedge clk); #2;
    chk("t4_addr_tg", instr_read_addr, 32'h0040_0010);
    chk1("t4_valid_tg", instr_valid, 1'b0);
    @(posedge clk); #2;
    chk1("t4_valid_w", instr_valid, 1'b1);
    chk("t4_word_w", instr_word, 32'hFFBF_FFEF);
    chk("t4_pc_w", instr_pc, 32'h0040_0010);

    // T5: redirect to the halt address
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0000;
    @(posedge clk); #1 redirect_valid = 1'b0; #1;
    chk1("t5_read0", instr_read, 1'b0);
    chk1("t5_valid0", instr_valid, 1'b0);
    chk1("t5_active0", active, 1'b1);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_addr = 32'h0040_0010; #1;
    chk1("t5_active1", active, 1'b0);
    chk1("t5_read1", instr_read, 1'b0);
    @(posedge clk); #1 redirect_valid = 1'b0; #1;
    chk1("t5_read2", instr_read, 1'b0);
    chk1("t5_active2", active, 1'b0);
    chk("t5_addr2", instr_read_addr, 32'h0000_0000);

    // T6: misaligned redirect
    do_reset();
    redirect_valid = 1'b1; redirect_addr = 32'h0040_0012;
    @(posedge clk); #1 redirect_valid = 1'b0; #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk1("t6_fault", fetch_fault, 1'b1);
    chk1("t6_active", active, 1'b0);
    chk1("t6_read", instr_read, 1'b0);
`else
    chk1("t6_fault", fetch_fault, 1'b0);
    chk1("t6_read", instr_read, 1'b1);
    chk("t6_addr", instr_read_addr, 32'h0040_0010);
`endif

    // T7: two redirects during one stall, last one wins
    do_reset();
    instr_waitrequest = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h0040_0040;
    @(posedge clk); #1 redirect_addr = 32'h0040_0080; #1;
    chk("t7_addr_dr", instr_read_addr, 32'hBFC0_0000);
    @(posedge clk); #1 redirect_valid = 1'b0; instr_waitrequest = 1'b0; #1;
    chk1("t7_valid_dr", instr_valid, 1'b0);
    @(posedge clk); #2;
    chk("t7_addr_tg", instr_read_addr, 32'h0040_0080);
    chk1("t7_valid_tg", instr_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
